// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_pkg
//  Purpose  : Shared definitions for the elastic pipeline register family:
//             stage-count limit, count_o width helper and the default MEM/WB
//             payload/control layouts so callers can pack and unpack fields.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  localparam int STAGES_MAX = 4;

  // Width needed to hold 0..2*stages (each stage holds main + skid entry).
  function automatic int count_w(input int stages);
    return $clog2(2 * stages + 1);
  endfunction

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] data;
    logic [4:0]  rd;
  } memwb_payload_t;

  typedef struct packed {
    logic mem_to_reg;
    logic reg_write;
  } memwb_ctrl_t;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_skid_stage.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_skid_stage
//  Purpose  : One elastic pipeline stage: main register plus skid register.
//             in_ready_o is the inverted skid flag, so it is purely registered
//             and never depends on out_ready_i in the same cycle.
//  Ports    : clk_i, rst_n_i          - clock, async active-low reset
//             flush_i                 - synchronous kill of held entries
//             in_valid_i/in_ready_o   - upstream handshake
//             in_data_i/in_ctrl_i     - incoming payload / control
//             out_valid_o/out_ready_i - downstream handshake
//             out_data_o/out_ctrl_o   - main register contents (unmasked)
//             fill_o                  - number of entries held (0..2)
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_skid_stage #(
  parameter int DATA_W = 69,
  parameter int CTRL_W = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [1:0]        fill_o
);

  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q,  m_data_d;
  logic [CTRL_W-1:0] m_ctrl_q,  m_ctrl_d;
  logic              s_valid_q, s_valid_d;
  logic [DATA_W-1:0] s_data_q,  s_data_d;
  logic [CTRL_W-1:0] s_ctrl_q,  s_ctrl_d;

  logic w_in_xfer;
  logic w_out_xfer;

  assign w_in_xfer  = in_valid_i & ~s_valid_q;
  assign w_out_xfer = m_valid_q & out_ready_i;

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_ctrl_d  = m_ctrl_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    s_ctrl_d  = s_ctrl_q;
    if (flush_i) begin
      // Flush wins over any same-cycle input transfer; data may stay stale.
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (w_out_xfer || !m_valid_q) begin
      if (s_valid_q) begin
        // Skid is older than anything upstream (ready was low), refill main.
        m_valid_d = 1'b1;
        m_data_d  = s_data_q;
        m_ctrl_d  = s_ctrl_q;
        s_valid_d = 1'b0;
      end else begin
        m_valid_d = w_in_xfer;
        if (w_in_xfer) begin
          m_data_d = in_data_i;
          m_ctrl_d = in_ctrl_i;
        end
      end
    end else if (w_in_xfer) begin
      // Main is stuck; ready was still high so park the entry in skid.
      s_valid_d = 1'b1;
      s_data_d  = in_data_i;
      s_ctrl_d  = in_ctrl_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_ctrl_q  <= '0;
      s_valid_q <= 1'b0;
      s_data_q  <= '0;
      s_ctrl_q  <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_ctrl_q  <= m_ctrl_d;
      s_valid_q <= s_valid_d;
      s_data_q  <= s_data_d;
      s_ctrl_q  <= s_ctrl_d;
    end
  end

  assign in_ready_o  = ~s_valid_q;
  assign out_valid_o = m_valid_q;
  assign out_data_o  = m_data_q;
  assign out_ctrl_o  = m_ctrl_q;
  assign fill_o      = {m_valid_q & s_valid_q, m_valid_q ^ s_valid_q};

endmodule : pipe_skid_stage
`default_nettype wire

// File: rtl/pipe_stage_elastic.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_elastic
//  Purpose  : Elastic pipeline register built from STAGES chained skid stages.
//             Adds occupancy count and forces the control field to zero on
//             bubbles so an empty slot never asserts write-back controls.
//  Ports    : clk_i, rst_n_i          - clock, async active-low reset
//             flush_i                 - synchronous kill of all entries
//             in_valid_i/in_ready_o   - upstream handshake (ready registered)
//             in_data_i/in_ctrl_i     - payload / control field in
//             out_valid_o/out_ready_i - downstream handshake
//             out_data_o/out_ctrl_o   - payload / masked control field out
//             count_o                 - entries currently held
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int DATA_W = $bits(memwb_payload_t),
  parameter int CTRL_W = $bits(memwb_ctrl_t),
  parameter int STAGES = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [DATA_W-1:0]          in_data_i,
  input  logic [CTRL_W-1:0]          in_ctrl_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [DATA_W-1:0]          out_data_o,
  output logic [CTRL_W-1:0]          out_ctrl_o,
  output logic [count_w(STAGES)-1:0] count_o
);

  localparam int CNT_W = count_w(STAGES);

  if (STAGES < 1 || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("pipe_stage_elastic: STAGES must be in 1..%0d", STAGES_MAX);
  end

  // Index k is the input side of stage k; index STAGES is the block output.
  logic              w_valid [STAGES+1];
  logic              w_ready [STAGES+1];
  logic [DATA_W-1:0] w_data  [STAGES+1];
  logic [CTRL_W-1:0] w_ctrl  [STAGES+1];
  logic [1:0]        w_fill  [STAGES];
  logic [CNT_W-1:0]  w_count;

  assign w_valid[0]      = in_valid_i;
  assign w_data[0]       = in_data_i;
  assign w_ctrl[0]       = in_ctrl_i;
  assign w_ready[STAGES] = out_ready_i;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    pipe_skid_stage #(
      .DATA_W (DATA_W),
      .CTRL_W (CTRL_W)
    ) u_stage (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .flush_i     (flush_i),
      .in_valid_i  (w_valid[k]),
      .in_ready_o  (w_ready[k]),
      .in_data_i   (w_data[k]),
      .in_ctrl_i   (w_ctrl[k]),
      .out_valid_o (w_valid[k+1]),
      .out_ready_i (w_ready[k+1]),
      .out_data_o  (w_data[k+1]),
      .out_ctrl_o  (w_ctrl[k+1]),
      .fill_o      (w_fill[k])
    );
  end

  always_comb begin
    w_count = '0;
    for (int k = 0; k < STAGES; k++) begin
      w_count = w_count + CNT_W'(w_fill[k]);
    end
  end

  assign in_ready_o  = w_ready[0];
  assign out_valid_o = w_valid[STAGES];
  assign out_data_o  = w_data[STAGES];
  assign out_ctrl_o  = w_ctrl[STAGES] & {CTRL_W{w_valid[STAGES]}};
  assign count_o     = w_count;

endmodule : pipe_stage_elastic
`default_nettype wire
